// File: rtl/day10_machine_scheduler.sv
// day10_machine_scheduler: sequences the input reader and the solver once per machine record and accumulates a total.
// Latency: 1 cycle from reader_ready to solver_start, and 1 cycle from solver_done to the next reader_start.
// Backpressure: none; the FSM waits for the reader and solver pulses, with a watchdog that moves it to ERROR.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   go                               start/restart request; sampled only in IDLE, DONE and ERROR
//   reader_start / reader_ready      pulse handshake with the input reader
//   end_of_input                     sticky flag from the reader: this record is the final one
//   solver_start / solver_done       pulse handshake with the solver
//   solver_min_presses               solver result, sampled on the solver_done cycle
//   total_presses, machines_done     saturating run totals
//   busy, done, timeout_err          status decoded from the state register
//
// Optional build macro DAY10_SCHED_STATS_EN adds two outputs:
//   max_presses (largest result in the run) and run_cycles (busy cycles, saturating).
module day10_machine_scheduler #(
    parameter int MAX_NUM_BUTTONS   = 16,
    parameter int MAX_NUM_BUTTONS_W = (MAX_NUM_BUTTONS <= 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    parameter int TOTAL_W           = 32,
    parameter int MACHINE_CNT_W     = 16,
    parameter int TIMEOUT_CYCLES    = 65535
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         go,
    output logic                         reader_start,
    input  logic                         reader_ready,
    input  logic                         end_of_input,
    output logic                         solver_start,
    input  logic                         solver_done,
    input  logic [MAX_NUM_BUTTONS_W-1:0] solver_min_presses,
    output logic [TOTAL_W-1:0]           total_presses,
    output logic [MACHINE_CNT_W-1:0]     machines_done,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_err
`ifdef DAY10_SCHED_STATS_EN
    ,
    output logic [MAX_NUM_BUTTONS_W-1:0] max_presses,
    output logic [31:0]                  run_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START_READ  = 3'd1,
        WAIT_READ   = 3'd2,
        START_SOLVE = 3'd3,
        WAIT_SOLVE  = 3'd4,
        DONE        = 3'd5,
        ERROR       = 3'd6
    } state_t;

    // The watchdog counter only ever needs to hold 0 .. TIMEOUT_CYCLES-1.
    localparam int WD_W = (TIMEOUT_CYCLES <= 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    // Adder wide enough for either operand plus a carry, so the saturation
    // test works whichever of TOTAL_W / MAX_NUM_BUTTONS_W is wider.
    localparam int SUM_W = ((TOTAL_W > MAX_NUM_BUTTONS_W) ? TOTAL_W : MAX_NUM_BUTTONS_W) + 1;
    localparam logic [TOTAL_W-1:0]       TOTAL_ONES = '1;
    localparam logic [MACHINE_CNT_W-1:0] MCNT_ONES  = '1;

    state_t                   state;
    logic [WD_W-1:0]          wd_cnt;
    logic                     last_flag;

    logic                     restart;
    logic                     wd_expire;
    logic [SUM_W-1:0]         sum_ext;
    logic [TOTAL_W-1:0]       total_next;
    logic [MACHINE_CNT_W-1:0] mcnt_next;

    // Status and start pulses are plain decodes of the state register.
    assign reader_start = (state == START_READ);
    assign solver_start = (state == START_SOLVE);
    assign done         = (state == DONE);
    assign timeout_err  = (state == ERROR);
    assign busy         = (state != IDLE) && (state != DONE) && (state != ERROR);

    // go only matters in the three resting states; while busy it is ignored.
    assign restart = go && !busy;

    // The counter holds the number of already-elapsed wait cycles, so the
    // cycle on which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

    always_comb begin
        sum_ext    = SUM_W'(total_presses) + SUM_W'(solver_min_presses);
        total_next = (sum_ext > SUM_W'(TOTAL_ONES)) ? TOTAL_ONES : sum_ext[TOTAL_W-1:0];
        mcnt_next  = (machines_done == MCNT_ONES) ? MCNT_ONES : (machines_done + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            total_presses <= '0;
            machines_done <= '0;
            wd_cnt        <= '0;
            last_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (go) begin
                        state         <= START_READ;
                        total_presses <= '0;
                        machines_done <= '0;
                        last_flag     <= 1'b0;
                    end
                end

                START_READ: begin
                    state  <= WAIT_READ;
                    wd_cnt <= '0;
                end

                WAIT_READ: begin
                    // An arriving pulse beats a watchdog expiring on the same cycle.
                    if (reader_ready) begin
                        last_flag <= end_of_input;
                        state     <= START_SOLVE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_expire) begin
                            state <= ERROR;
                        end
                    end
                end

                START_SOLVE: begin
                    state  <= WAIT_SOLVE;
                    wd_cnt <= '0;
                end

                WAIT_SOLVE: begin
                    if (solver_done) begin
                        total_presses <= total_next;
                        machines_done <= mcnt_next;
                        state         <= last_flag ? DONE : START_READ;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (wd_expire) begin
                            state <= ERROR;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DAY10_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_presses <= '0;
            run_cycles  <= '0;
        end else if (restart) begin
            max_presses <= '0;
            run_cycles  <= '0;
        end else begin
            if ((state == WAIT_SOLVE) && solver_done && (solver_min_presses > max_presses)) begin
                max_presses <= solver_min_presses;
            end
            if (busy && (run_cycles != 32'hFFFF_FFFF)) begin
                run_cycles <= run_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_day10_machine_scheduler.sv
// tb_day10_machine_scheduler: directed bench for the Day 10 machine scheduler.
// Latency: stimulus changes 1 time unit after each rising edge; checks are made at the same point.
// Backpressure: the bench plays reader and solver with fixed, short response delays.
module tb_day10_machine_scheduler;

    localparam int MB   = 16;
    localparam int MB_W = 5;
    localparam int TW   = 4;
    localparam int MW   = 16;
    localparam int TO   = 8;

    logic            clk;
    logic            rst_n;
    logic            go;
    logic            reader_start;
    logic            reader_ready;
    logic            end_of_input;
    logic            solver_start;
    logic            solver_done;
    logic [MB_W-1:0] solver_min_presses;
    logic [TW-1:0]   total_presses;
    logic [MW-1:0]   machines_done;
    logic            busy;
    logic            done;
    logic            timeout_err;
`ifdef DAY10_SCHED_STATS_EN
    logic [MB_W-1:0] max_presses;
    logic [31:0]     run_cycles;
`endif

    int total;
    int bad;
    int rs_cnt;
    int ss_cnt;
    int busy_cnt;
    int rs_base;
    int ss_base;
    int busy_base;

    day10_machine_scheduler #(
        .MAX_NUM_BUTTONS    (MB),
        .MAX_NUM_BUTTONS_W  (MB_W),
        .TOTAL_W            (TW),
        .MACHINE_CNT_W      (MW),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .go                 (go),
        .reader_start       (reader_start),
        .reader_ready       (reader_ready),
        .end_of_input       (end_of_input),
        .solver_start       (solver_start),
        .solver_done        (solver_done),
        .solver_min_presses (solver_min_presses),
        .total_presses      (total_presses),
        .machines_done      (machines_done),
        .busy               (busy),
        .done               (done),
        .timeout_err        (timeout_err)
`ifdef DAY10_SCHED_STATS_EN
        ,
        .max_presses        (max_presses),
        .run_cycles         (run_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, mid-cycle.
    initial begin
        rs_cnt   = 0;
        ss_cnt   = 0;
        busy_cnt = 0;
    end
    always @(negedge clk) begin
        if (reader_start) rs_cnt++;
        if (solver_start) ss_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    // Entered with the DUT in START_READ. Answers the reader after d extra
    // wait cycles and the solver immediately with result res.
    task automatic do_machine(input int d, input logic [MB_W-1:0] res);
        tick();
        repeat (d) tick();
        reader_ready = 1'b1;
        tick();
        reader_ready = 1'b0;
        tick();
        solver_done        = 1'b1;
        solver_min_presses = res;
        tick();
        solver_done        = 1'b0;
        solver_min_presses = '0;
    endtask

    initial begin
        total              = 0;
        bad                = 0;
        rst_n              = 1'b0;
        go                 = 1'b0;
        reader_ready       = 1'b0;
        end_of_input       = 1'b0;
        solver_done        = 1'b0;
        solver_min_presses = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy",   32'(busy), 0);
        chk("rst_done",   32'(done), 0);
        chk("rst_terr",   32'(timeout_err), 0);
        chk("rst_rstart", 32'(reader_start), 0);
        chk("rst_sstart", 32'(solver_start), 0);
        chk("rst_total",  32'(total_presses), 0);
        chk("rst_mdone",  32'(machines_done), 0);
        rst_n = 1'b1;
        tick();

        // Three machines: 2, 3, 2; end_of_input before the third record
        rs_base = rs_cnt;
        ss_base = ss_cnt;
        pulse_go();
        chk("t1_rstart0", 32'(reader_start), 1);
        chk("t1_busy",    32'(busy), 1);
        do_machine(1, 5'd2);
        chk("t1_rstart1", 32'(reader_start), 1);
        chk("t1_total1",  32'(total_presses), 2);
        do_machine(0, 5'd3);
        end_of_input = 1'b1;
        do_machine(2, 5'd2);
        chk("t1_done",    32'(done), 1);
        chk("t1_busy_lo", 32'(busy), 0);
        chk("t1_total",   32'(total_presses), 7);
        chk("t1_mdone",   32'(machines_done), 3);
        chk("t1_nrs",     32'(rs_cnt - rs_base), 3);
        chk("t1_nss",     32'(ss_cnt - ss_base), 3);
        // A stray reader_ready in DONE changes nothing
        reader_ready = 1'b1;
        tick();
        reader_ready = 1'b0;
        tick();
        chk("t1_hold_done",  32'(done), 1);
        chk("t1_hold_total", 32'(total_presses), 7);
        chk("t1_hold_nrs",   32'(rs_cnt - rs_base), 3);

        // Single machine with end_of_input already high, result 0
        rs_base = rs_cnt;
        pulse_go();
        chk("t2_total_clr", 32'(total_presses), 0);
        chk("t2_mdone_clr", 32'(machines_done), 0);
        do_machine(0, 5'd0);
        chk("t2_done",  32'(done), 1);
        chk("t2_total", 32'(total_presses), 0);
        chk("t2_mdone", 32'(machines_done), 1);
        repeat (3) tick();
        chk("t2_nrs",   32'(rs_cnt - rs_base), 1);

        // Watchdog: reader never answers after one machine (total 4)
        end_of_input = 1'b0;
        pulse_go();
        do_machine(0, 5'd4);
        chk("t3_total4", 32'(total_presses), 4);
        tick();                              // enters WAIT_READ
        solver_done        = 1'b1;           // wrong pulse for this state
        solver_min_presses = 5'd5;
        tick();
        solver_done        = 1'b0;
        solver_min_presses = '0;
        repeat (6) tick();                   // 8th WAIT_READ cycle
        chk("t3_terr_pre",  32'(timeout_err), 0);
        chk("t3_busy_pre",  32'(busy), 1);
        chk("t3_total_ign", 32'(total_presses), 4);
        tick();
        chk("t3_terr",      32'(timeout_err), 1);
        chk("t3_busy",      32'(busy), 0);
        chk("t3_done",      32'(done), 0);
        chk("t3_total_hld", 32'(total_presses), 4);
        chk("t3_mdone_hld", 32'(machines_done), 1);
        pulse_go();
        chk("t3_terr_clr",  32'(timeout_err), 0);
        chk("t3_restart",   32'(reader_start), 1);
        chk("t3_total_clr", 32'(total_presses), 0);
        chk("t3_mdone_clr", 32'(machines_done), 0);

        // Pulse arriving on the limit cycle wins over the watchdog
        tick();
        repeat (7) tick();
        reader_ready = 1'b1;
        tick();
        reader_ready = 1'b0;
        chk("t3_win_ss",   32'(solver_start), 1);
        chk("t3_win_terr", 32'(timeout_err), 0);
        tick();
        solver_done        = 1'b1;
        solver_min_presses = 5'd2;
        reader_ready       = 1'b1;           // simultaneous, only solver_done counts
        tick();
        solver_done        = 1'b0;
        reader_ready       = 1'b0;
        solver_min_presses = '0;
        chk("t3_both_rs",    32'(reader_start), 1);
        chk("t3_both_total", 32'(total_presses), 2);

        // Reset in WAIT_SOLVE after total 5
        do_machine(0, 5'd3);
        chk("t4_total5", 32'(total_presses), 5);
        chk("t4_mdone2", 32'(machines_done), 2);
        tick();
        reader_ready = 1'b1;
        tick();
        reader_ready = 1'b0;
        tick();
        chk("t4_busy_ws", 32'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_busy",  32'(busy), 0);
        chk("t4_total", 32'(total_presses), 0);
        chk("t4_mdone", 32'(machines_done), 0);
        chk("t4_done",  32'(done), 0);
        solver_done        = 1'b1;
        solver_min_presses = 5'd7;
        tick();
        solver_done        = 1'b0;
        solver_min_presses = '0;
        chk("t4_ign_total", 32'(total_presses), 0);
        chk("t4_ign_busy",  32'(busy), 0);

        // Saturation 9 + 9 on a 4-bit total; go while busy is ignored
        pulse_go();
        do_machine(0, 5'd9);
        chk("t5_total9", 32'(total_presses), 9);
        tick();                              // WAIT_READ
        pulse_go();
        chk("t5_go_rs",   32'(reader_start), 0);
        chk("t5_go_busy", 32'(busy), 1);
        end_of_input = 1'b1;
        reader_ready = 1'b1;
        tick();
        reader_ready = 1'b0;
        tick();
        solver_done        = 1'b1;
        solver_min_presses = 5'd9;
        tick();
        solver_done        = 1'b0;
        solver_min_presses = '0;
        chk("t5_done",  32'(done), 1);
        chk("t5_total", 32'(total_presses), 15);
        chk("t5_mdone", 32'(machines_done), 2);

`ifdef DAY10_SCHED_STATS_EN
        // Results 1, 5, 3: busy cycles (4+0)+(4+1)+(4+2) = 15
        end_of_input = 1'b0;
        pulse_go();
        busy_base = busy_cnt;
        chk("s_max_clr", 32'(max_presses), 0);
        do_machine(0, 5'd1);
        do_machine(1, 5'd5);
        end_of_input = 1'b1;
        do_machine(2, 5'd3);
        chk("s_done",     32'(done), 1);
        chk("s_total",    32'(total_presses), 9);
        chk("s_max",      32'(max_presses), 5);
        chk("s_cycles",   run_cycles, 15);
        chk("s_busycnt",  run_cycles, 32'(busy_cnt - busy_base));
        tick();
        chk("s_hold",     run_cycles, 15);
`else
        busy_base = busy_cnt;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/day10_machine_scheduler.md
Name: day10_machine_scheduler

Overview:
Top-level sequencer for Day 10 part-1 processing. It repeatedly pulses the input reader to parse one machine record, then hands the parsed record to the button-press solver. It collects the solver's minimum-press count into a running total and stops after the machine flagged by end_of_input. It sits between the host go/done interface, day10_input_reader (start/reader_ready/end_of_input) and the solver core (solver_start/solver_done).

Parameters:
MAX_NUM_BUTTONS, 16, max buttons per machine; the solver result never exceeds this.
MAX_NUM_BUTTONS_W, $clog2(MAX_NUM_BUTTONS+1) (1 if MAX_NUM_BUTTONS<=1), width of solver_min_presses.
TOTAL_W, 32, width of total_presses.
MACHINE_CNT_W, 16, width of machines_done.
TIMEOUT_CYCLES, 65535, watchdog limit per wait phase; 0 disables the watchdog.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
go  in  1  start/restart request; sampled only in IDLE, DONE and ERROR.
reader_start  out  1  one-cycle start pulse to the input reader.
reader_ready  in  1  one-cycle pulse: reader has a complete machine record.
end_of_input  in  1  sticky flag from the reader: the final record has been consumed.
solver_start  out  1  one-cycle start pulse to the solver.
solver_done  in  1  one-cycle pulse: solver result is valid.
solver_min_presses  in  MAX_NUM_BUTTONS_W  minimum presses for the current machine; valid with solver_done.
total_presses  out  TOTAL_W  running sum of solver results.
machines_done  out  MACHINE_CNT_W  count of machines accumulated.
busy  out  1  high in every state except IDLE, DONE and ERROR.
done  out  1  high while in DONE.
timeout_err  out  1  high while in ERROR.

Behaviour:
- Reset (rst_n=0 at posedge), from any state including mid-operation:
  - state<=IDLE.
  - total_presses, machines_done, watchdog counter and last_flag all <=0.
  - All outputs 0 on the following cycle.
- States: IDLE, START_READ, WAIT_READ, START_SOLVE, WAIT_SOLVE, DONE, ERROR.
- IDLE: go -> START_READ. Same edge clears total_presses, machines_done and last_flag.
- START_READ: reader_start=1 (combinational from state; exactly one cycle). Unconditional -> WAIT_READ.
- WAIT_READ:
  - On reader_ready: last_flag<=end_of_input; -> START_SOLVE.
  - A reader_ready pulse arriving in any other state is ignored.
- START_SOLVE: solver_start=1 for one cycle. -> WAIT_SOLVE.
- WAIT_SOLVE, on solver_done:
  - total_presses <= total_presses + zero-extended solver_min_presses, saturating at all-ones.
  - machines_done increments, saturating.
  - Next state: last_flag ? DONE : START_READ.
- Latency: minimum 1 cycle from reader_ready to solver_start, and 1 cycle from solver_done to the next reader_start.
- DONE:
  - done=1; totals held stable.
  - go -> START_READ, clearing totals, identical to IDLE. This supports a re-run with a new stream.
- Watchdog:
  - Counter clears on entry to WAIT_READ and WAIT_SOLVE, and increments each cycle in those states.
  - When the counter reaches TIMEOUT_CYCLES without the awaited pulse: -> ERROR.
  - If the pulse arrives on the same cycle the limit is reached, the pulse wins.
  - TIMEOUT_CYCLES=0: the counter is never compared.
- ERROR:
  - timeout_err=1; totals held.
  - go -> START_READ with totals cleared; timeout_err drops.
- go while busy: ignored.
- Simultaneous reader_ready and solver_done: only the pulse matching the current wait state is acted on.
- solver_min_presses is sampled only on the solver_done cycle.

Optional Feature:
Macro DAY10_SCHED_STATS_EN.
- Defined, adds two outputs, both cleared on reset and on go-restart:
  - max_presses [MAX_NUM_BUTTONS_W]: largest solver_min_presses seen in the run.
  - run_cycles [32]: cycles spent busy, saturating.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Three machines with results 2, 3, 2; end_of_input rises before the third reader_ready -> three reader_start and three solver_start pulses; done=1 with total_presses=7 and machines_done=3.
- Single machine, end_of_input already 1 at the first reader_ready, result 0 -> DONE with total_presses=0, machines_done=1, and no second reader_start.
- TIMEOUT_CYCLES=8; reader_ready is never asserted -> ERROR with timeout_err=1 exactly 8 cycles after entering WAIT_READ. A following go restarts with totals 0.
- rst_n=0 asserted in WAIT_SOLVE after two machines accumulated (total 5) -> next cycle IDLE with total_presses=0, machines_done=0, busy=0; a later solver_done is ignored.
- TOTAL_W=4 with results 9 and 9 -> total_presses saturates at 15; go pulsed during WAIT_READ causes no state change.
- With DAY10_SCHED_STATS_EN defined and results 1, 5, 3 -> max_presses=5 and run_cycles equal to the busy cycle count.
